// File: rtl/down_counter_pkg.sv
// Shared counter definitions: FSM state encoding and the count input mux select.
package down_counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_LOAD   = 2'd0,
        SEL_DEC    = 2'd1,
        SEL_RELOAD = 2'd2
    } cnt_sel_e;

    // A freshly written start value only runs if there is something to count.
    function automatic state_e start_state(input logic nonzero);
        return nonzero ? S_RUN : S_IDLE;
    endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell, the arithmetic primitive shared by the counters.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/n_bit_decrementer.sv
// Ripple chain of fa cells computing a-1 as a + all-ones, mirroring the up-counter increment chain.
module n_bit_decrementer #(
    parameter int SIZE = 10
) (
    input  logic [SIZE-1:0] a,
    output logic [SIZE-1:0] diff,
    output logic            cout
);

    logic [SIZE:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < SIZE; i++) begin : g_cell
        fa u_fa (
            .a    (a[i]),
            .b    (1'b1),
            .cin  (carry[i]),
            .s    (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[SIZE];

endmodule

// File: rtl/n_bit_reg.sv
// SIZE-bit register with parallel enable and synchronous active-high clear.
module n_bit_reg #(
    parameter int SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pen,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] data_d;
    logic [SIZE-1:0] data_q;

    always_comb begin
        data_d = pen ? d : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter / countdown timer with one-cycle done pulse and optional auto-reload.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [SIZE-1:0] ld_val,
    input  logic            dec,
    input  logic            reload_en,
    output logic [SIZE-1:0] count,
    output logic            zero,
    output logic            busy,
    output logic            done
);

    state_e          state_d, state_q;
    logic            busy_d, busy_q;
    logic            done_d, done_q;
    cnt_sel_e        count_sel;
    logic            count_pen;
    logic            reload_pen;
    logic [SIZE-1:0] count_d, count_q;
    logic [SIZE-1:0] reload_q;
    logic [SIZE-1:0] dec_val;
    logic            dec_cout;

    n_bit_decrementer #(.SIZE(SIZE)) u_dec (
        .a    (count_q),
        .diff (dec_val),
        .cout (dec_cout)
    );

    n_bit_reg #(.SIZE(SIZE)) u_count_reg (
        .clk (clk),
        .rst (rst),
        .pen (count_pen),
        .d   (count_d),
        .q   (count_q)
    );

    n_bit_reg #(.SIZE(SIZE)) u_reload_reg (
        .clk (clk),
        .rst (rst),
        .pen (reload_pen),
        .d   (ld_val),
        .q   (reload_q)
    );

    always_comb begin
        state_d    = state_q;
        count_sel  = SEL_DEC;
        count_pen  = 1'b0;
        reload_pen = 1'b0;
        if (ld) begin
            count_sel  = SEL_LOAD;
            count_pen  = 1'b1;
            reload_pen = 1'b1;
            state_d    = start_state(ld_val != '0);
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RUN: begin
                    if (dec) begin
                        count_sel = SEL_DEC;
                        count_pen = 1'b1;
                        // Decremented value of zero means count was 1: terminal count.
                        if (dec_val == '0) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (reload_en) begin
                        count_sel = SEL_RELOAD;
                        count_pen = 1'b1;
                        state_d   = start_state(reload_q != '0);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (count_sel)
            SEL_LOAD:   count_d = ld_val;
            SEL_RELOAD: count_d = reload_q;
            default:    count_d = dec_val;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    // count + all-ones carries out for every nonzero count, so no carry means zero.
    assign zero  = ~dec_cout;

endmodule
